ct_lsu_dcache_tag_array_pw: RTL
===============================

Name: ct_lsu_dcache_tag_array_pw

Overview:
- Parametrised successor to the fixed 2-way, 54-bit L1 D-cache load tag array wrapper. Targets the next LSU generation.
- Configurable way count, tag width and depth. Behavioural single-port storage with per-way write enables.
- Adds per-way even parity (generated on write, checked on read), a registered read output with a valid strobe, and a hardware invalidate-sweep FSM that clears every index after reset or on request.
- Sits between the LSU load pipeline tag-access stage and the tag storage.

Parameters:
- WAYS, 2, number of ways; each way is stored as TAG_W+1 bits (tag plus parity).
- TAG_W, 27, tag-plus-state bits per way.
- DEPTH, 512, number of sets; must be a power of two and at least 2.
- IDX_W, 9, index width; equals log2(DEPTH).

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  synchronous active-high reset
- tag_sel_b  in  1  access select, active low
- tag_gwen_b  in  1  global write enable, active low; 1 = read
- tag_wen_b  in  WAYS  per-way write enable, active low; only meaningful when tag_gwen_b=0
- tag_idx  in  IDX_W  set index
- tag_din  in  WAYS*TAG_W  write data; way w occupies [w*TAG_W +: TAG_W]
- tag_inv_req  in  1  one-cycle pulse requesting an invalidate sweep of all sets
- tag_dout  out  WAYS*TAG_W  registered read data, same packing as tag_din
- tag_dout_vld  out  1  high for one cycle when tag_dout carries fresh read data
- tag_perr  out  WAYS  per-way parity error; qualified by tag_dout_vld
- tag_init_done  out  1  high when the array accepts requests

Behaviour:
- Reset (cpurst=1 at a clock edge):
  - tag_dout=0, tag_dout_vld=0, tag_perr=0, tag_init_done=0.
  - FSM enters INIT with sweep counter=0.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- FSM states and transitions:
  - INIT: each cycle writes all-zero tag and parity 0 to every way at sweep counter, then increments the counter. The write at DEPTH-1 moves the FSM to READY in the next cycle.
  - A full sweep takes exactly DEPTH cycles. tag_init_done rises the cycle after the DEPTH-1 write.
  - READY: tag_init_done=1; external accesses are accepted.
  - A tag_inv_req seen in READY moves the FSM to INIT on the next edge, clears tag_init_done and zeroes the counter. The request cycle itself still services any access presented with it.
  - tag_inv_req seen while already in INIT is ignored; the counter does not restart.
- Access acceptance:
  - An access is accepted only when tag_init_done=1 and tag_sel_b=0.
  - In INIT, external accesses are dropped: no storage change, no tag_dout_vld. The caller must wait for tag_init_done.
- Write (accepted, tag_gwen_b=0):
  - Each way w with tag_wen_b[w]=0 stores its slice of tag_din plus parity = XOR of that slice. Ways with tag_wen_b[w]=1 keep their contents.
  - tag_dout and tag_dout_vld are unchanged by a write.
- Read (accepted, tag_gwen_b=1):
  - One-cycle latency: in the next cycle tag_dout holds the stored tags and tag_dout_vld=1.
  - tag_perr[w]=1 when the XOR of the stored tag and stored parity for way w is 1.
- Output hold:
  - With no accepted read, tag_dout holds its last value, SRAM-style.
  - tag_dout_vld=0 and tag_perr=0 whenever tag_dout_vld=0.
- Port contention: the array is single-port, so at most one access per cycle. A read of an index written in the previous cycle returns the new data.
- Clock gating: none inside this block. Callers gate at the LSU top.
- Verification-only hook: a parity-flip backdoor task on the storage is permitted for parity tests. It is not a port.

Test Plan:
- Reset then idle, default parameters: tag_init_done stays 0 for exactly 512 cycles after reset deasserts, then rises. Reading every index afterwards returns 0 with tag_perr=0.
- With tag_init_done=1: write idx=5, tag_wen_b=2'b10, way0 data=27'h1ABCDEF, then read idx=5. Next cycle tag_dout[26:0]=27'h1ABCDEF, tag_dout[53:27]=0, tag_dout_vld=1, tag_perr=0.
- Back-to-back: write idx=7, then read idx=7 in the following cycle. The read returns the new data. With tag_sel_b=1 on the cycle after that, tag_dout_vld drops to 0 while tag_dout holds its value.
- Parity: backdoor-flip bit 3 of way1 at idx=20, then read idx=20. Required: tag_perr=2'b10 and tag_dout_vld=1.
- Invalidate: fill idx 0..3 with nonzero data, then pulse tag_inv_req while a read is issued.
  - The read completes.
  - tag_init_done=0 for 512 cycles; a read issued during that window produces no tag_dout_vld.
  - After the sweep, reads of idx 0..3 return 0.
- Reset mid-sweep: assert cpurst at sweep cycle 100. tag_init_done then rises exactly 512 cycles after cpurst deasserts. Repeat with WAYS=4, TAG_W=30, DEPTH=256 and check the same properties (256-cycle sweep).

Source files
------------

// File: rtl/ct_lsu_dcache_tag_array_pw.sv
// ct_lsu_dcache_tag_array_pw: parametrised parity-protected L1 D-cache tag array with invalidate sweep
module ct_lsu_dcache_tag_array_pw #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 27,
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    tag_sel_b,
  input  logic                    tag_gwen_b,
  input  logic [WAYS-1:0]         tag_wen_b,
  input  logic [IDX_W-1:0]        tag_idx,
  input  logic [WAYS*TAG_W-1:0]   tag_din,
  input  logic                    tag_inv_req,
  output logic [WAYS*TAG_W-1:0]   tag_dout,
  output logic                    tag_dout_vld,
  output logic [WAYS-1:0]         tag_perr,
  output logic                    tag_init_done
);
  localparam int EW = TAG_W + 1;
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic [WAYS*EW-1:0] mem [DEPTH];
  logic [WAYS*EW-1:0] rdata, wdata, wmask;
  logic [WAYS*TAG_W-1:0] rtag;
  logic [WAYS-1:0] rpe;
  logic acc, rd, wr;
  assign acc = tag_init_done & ~tag_sel_b;
  assign rd  = acc & tag_gwen_b;
  assign wr  = acc & ~tag_gwen_b;
  // per-way packing: each way stores {parity, tag}; parity recomputed on read to flag corruption
  always_comb begin
    rdata = mem[tag_idx];
    wdata = '0;
    wmask = '0;
    rtag  = '0;
    rpe   = '0;
    for (int w = 0; w < WAYS; w++) begin
      wdata[w*EW +: EW]    = {^tag_din[w*TAG_W +: TAG_W], tag_din[w*TAG_W +: TAG_W]};
      wmask[w*EW +: EW]    = {EW{~tag_wen_b[w]}};
      rtag[w*TAG_W +: TAG_W] = rdata[w*EW +: TAG_W];
      rpe[w]               = ^rdata[w*EW +: EW];
    end
  end
  // storage: sweep clears one set per cycle, otherwise masked write merges enabled ways
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst && state == INIT) mem[cnt] <= '0;
    else if (!cpurst && wr) mem[tag_idx] <= (rdata & ~wmask) | (wdata & wmask);
  end
  // sweep FSM: INIT walks every index once, READY accepts traffic until an invalidate request
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state         <= INIT;
      cnt           <= '0;
      tag_init_done <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == IDX_W'(DEPTH - 1)) begin
        state         <= READY;
        tag_init_done <= 1'b1;
      end
    end else if (tag_inv_req) begin
      state         <= INIT;
      cnt           <= '0;
      tag_init_done <= 1'b0;
    end
  end
  // registered read port: data holds between reads, valid and parity pulse only on a read
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      tag_dout     <= '0;
      tag_dout_vld <= 1'b0;
      tag_perr     <= '0;
    end else begin
      tag_dout_vld <= rd;
      tag_perr     <= rd ? rpe : '0;
      if (rd) tag_dout <= rtag;
    end
  end
endmodule
